fifo_rr_arbiter: RTL

- Round-robin arbiter that shares the enqueue port of one `fifo` instance among NUM_REQ producers.
- Each producer has its own valid/ready/packet channel. The block drives the FIFO's in_valid/in_ready/packet_in through its out_* port.
- The selected source is locked while the FIFO back-pressures, so each producer sees a stable valid/ready handshake and the FIFO sees a stable packet.

---
 rtl/fifo_rr_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin arbiter sharing one FIFO enqueue port among
// NUM_REQ producers. The winner is locked while the FIFO back-pressures, so
// the presented packet and source index stay stable until accepted.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   per-requester valid
//   req_ready   per-requester ready (one-hot or zero)
//   req_packet  packed packets, requester i at [i*PKT_W +: PKT_W]
//   out_valid   to FIFO in_valid
//   out_ready   from FIFO in_ready (combinational path to req_ready)
//   out_packet  to FIFO packet_in
//   out_src     index of requester currently presented
//
// Optional build macro ARB_STATS_EN adds:
//   acc_count   NUM_REQ x 16-bit saturating transfer counters
//   starve_flag sticky: some requester waited > 4*NUM_REQ cycles ungranted
module fifo_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PKT_W   = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*PKT_W-1:0] req_packet,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PKT_W-1:0]         out_packet,
  output logic [IDX_W-1:0]         out_src
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    acc_count,
  output logic                     starve_flag
`endif
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_lock_idx, w_lock_nxt;
  logic [IDX_W-1:0] w_sel, w_cur;
  logic             w_found, w_valid, w_xfer;
  logic [PKT_W-1:0] w_pkts [NUM_REQ];

  // (base + k) mod NUM_REQ for k < NUM_REQ; works for non-power-of-two counts
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= NUM_REQ) t = t - NUM_REQ;
    return t[IDX_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_pkts[g] = req_packet[g*PKT_W +: PKT_W];
  end

  // Rotating priority search starting at r_rr_ptr. Descending loop so the
  // smallest offset (highest priority) is the last, winning assignment.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_rr_ptr;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_sel   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  // Presented source; outputs are forced quiet while reset is held so a
  // pending request cannot leak through the combinational path.
  always_comb begin
    w_cur   = w_sel;
    w_valid = w_found;
    if (r_state == LOCK) begin
      w_cur   = r_lock_idx;
      w_valid = req_valid[r_lock_idx];
    end
    if (!reset) begin
      w_cur   = '0;
      w_valid = 1'b0;
    end
  end

  assign w_xfer     = w_valid && out_ready;
  assign out_valid  = w_valid;
  assign out_src    = w_cur;
  assign out_packet = w_pkts[w_cur];
  assign req_ready  = w_xfer ? (NUM_REQ'(1) << w_cur) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ARB;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_lock_idx <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_lock_nxt  = r_lock_idx;
    case (r_state)
      ARB: begin
        if (w_found) begin
          if (out_ready) begin
            w_ptr_nxt = wrap_add(w_sel, 1);
          end else begin
            w_state_nxt = LOCK;
            w_lock_nxt  = w_sel;
          end
        end
      end
      LOCK: begin
        // A dropped valid here is a protocol violation; we simply stay put.
        if (w_xfer) begin
          w_state_nxt = ARB;
          w_ptr_nxt   = wrap_add(r_lock_idx, 1);
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

`ifdef ARB_STATS_EN
  localparam int STARVE_LIM = 4*NUM_REQ;
  localparam int WAIT_W     = $clog2(STARVE_LIM+2);

  logic [NUM_REQ-1:0][15:0]       r_acc;
  logic [NUM_REQ-1:0][WAIT_W-1:0] r_wait;
  logic                           r_starve;

  // r_wait counts consecutive ungranted valid cycles, saturating one past the
  // limit; reaching that value means the requester waited too long.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_wait   <= '0;
      r_starve <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && r_acc[i] != 16'hFFFF) r_acc[i] <= r_acc[i] + 16'd1;
        if (req_valid[i] && !req_ready[i]) begin
          if (r_wait[i] != WAIT_W'(STARVE_LIM+1)) r_wait[i] <= r_wait[i] + WAIT_W'(1);
        end else begin
          r_wait[i] <= '0;
        end
        if (r_wait[i] == WAIT_W'(STARVE_LIM+1)) r_starve <= 1'b1;
      end
    end
  end

  assign acc_count   = r_acc;
  assign starve_flag = r_starve;
`endif

  a_ready_onehot: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(req_ready));
  a_hold_stable: assert property (@(posedge clock) disable iff (!reset)
    out_valid && !out_ready |=> out_valid && $stable(out_packet) && $stable(out_src));
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy_chk
    a_ready_legal: assert property (@(posedge clock) disable iff (!reset)
      req_ready[g] |-> req_valid[g] && out_ready);
  end

endmodule
